// File: rtl/serial_fir_ctrl_if.sv
// Signal bundle between the serial FIR sequencer and its sample source,
// coefficient store, delay-line SRAM and result sink.
interface serial_fir_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 8,
  parameter int AWIDTH = 6,
  parameter int OWIDTH = DWIDTH + CWIDTH + AWIDTH
);
  // din and dout are valid/ready: a word transfers on the posedge where valid and
  // ready are both high; the producer holds valid and its data stable until then.
  logic              din_valid;
  logic              din_ready;
  logic [DWIDTH-1:0] din_data;
  logic [AWIDTH-1:0] coef_addr;
  logic [CWIDTH-1:0] coef_data;
  logic [AWIDTH-1:0] sram_address;
  logic              sram_write_req;
  logic [DWIDTH-1:0] sram_write_data;
  logic [DWIDTH-1:0] sram_read_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [OWIDTH-1:0] dout_data;

  modport slave (
    input  din_valid, din_data, coef_data, sram_read_data, dout_ready,
    output din_ready, coef_addr, sram_address, sram_write_req, sram_write_data,
           dout_valid, dout_data
  );

  modport master (
    output din_valid, din_data, coef_data, sram_read_data, dout_ready,
    input  din_ready, coef_addr, sram_address, sram_write_req, sram_write_data,
           dout_valid, dout_data
  );
endinterface

// File: rtl/serial_fir_ctrl.sv
// Serial FIR sequencer: single-port SRAM used as a circular delay line, one
// multiply-accumulate per cycle, one result per accepted sample.
module serial_fir_ctrl #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 8,
  parameter int AWIDTH = 6,
  parameter int TAPS   = 64,
  parameter int OWIDTH = DWIDTH + CWIDTH + AWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  serial_fir_ctrl_if.slave bus,
  output logic [1:0]       o_dbg_state
);
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;
  localparam int PWIDTH = DWIDTH + CWIDTH;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(TAPS - 1);

  logic [1:0]               r_state;
  logic [AWIDTH-1:0]        r_clr_cnt;
  logic [AWIDTH-1:0]        r_wr_ptr;
  logic [AWIDTH-1:0]        r_rd_ptr;
  logic [AWIDTH-1:0]        r_k;
  logic [OWIDTH-1:0]        r_acc;
  logic [OWIDTH-1:0]        r_dout;
  logic signed [PWIDTH-1:0] w_sample_x;
  logic signed [PWIDTH-1:0] w_coef_x;
  logic signed [PWIDTH-1:0] w_prod;
  logic [OWIDTH-1:0]        w_acc_next;

  assign w_sample_x = PWIDTH'($signed(bus.sram_read_data));
  assign w_coef_x   = PWIDTH'($signed(bus.coef_data));
  assign w_prod     = w_sample_x * w_coef_x;
  assign w_acc_next = r_acc + {{(OWIDTH-PWIDTH){w_prod[PWIDTH-1]}}, w_prod};

  assign bus.dout_data = r_dout;
  assign o_dbg_state   = r_state;

  // Handshake outputs are forced low while rst is high, whatever the state holds.
  always_comb begin
    bus.din_ready       = 1'b0;
    bus.dout_valid      = 1'b0;
    bus.sram_write_req  = 1'b0;
    bus.sram_write_data = '0;
    bus.sram_address    = '0;
    bus.coef_addr       = '0;
    if (!rst) begin
      case (r_state)
        S_CLEAR: begin
          bus.sram_address   = r_clr_cnt;
          bus.sram_write_req = 1'b1;
        end
        S_IDLE: begin
          bus.din_ready       = 1'b1;
          bus.sram_address    = r_wr_ptr;
          bus.sram_write_data = bus.din_data;
          bus.sram_write_req  = bus.din_valid;
        end
        S_MAC: begin
          bus.sram_address = r_rd_ptr;
          bus.coef_addr    = r_k;
        end
        default: bus.dout_valid = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == LAST) begin
            r_clr_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + AWIDTH'(1);
          end
        end
        S_IDLE: begin
          if (bus.din_valid) begin
            // The newest sample sits at wr_ptr; the MAC walks backwards from it.
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AWIDTH'(1);
            r_acc    <= '0;
            r_k      <= '0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc    <= w_acc_next;
          r_rd_ptr <= (r_rd_ptr == '0) ? LAST : r_rd_ptr - AWIDTH'(1);
          r_k      <= r_k + AWIDTH'(1);
          if (r_k == LAST) begin
            r_dout  <= w_acc_next;
            r_state <= S_OUT;
          end
        end
        default: begin
          if (bus.dout_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fir_ctrl.sv
// Bench for serial_fir_ctrl: three instances (TAPS 4, 5, 64) with behavioural
// coefficient stores and SRAMs, results checked against a reference filter.
module tb_serial_fir_ctrl;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 6;
  localparam int OW = DW + CW + AW;
  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[NU];
  logic          din_valid[NU];
  logic [DW-1:0] din_data[NU];
  logic          dout_ready[NU];
  logic          din_ready[NU];
  logic [AW-1:0] coef_addr[NU];
  logic [AW-1:0] sram_address[NU];
  logic          sram_write_req[NU];
  logic [DW-1:0] sram_write_data[NU];
  logic          dout_valid[NU];
  logic [OW-1:0] dout_data[NU];
  logic [1:0]    dbg_state[NU];

  logic signed [CW-1:0] coef_tab[NU][64];
  logic [DW-1:0]        mem[NU][64];
  logic signed [DW-1:0] hist[NU][64];
  logic [OW-1:0]        exp_q[$];
  int                   addr_bad[NU];
  int                   n_vec = 0;
  int                   n_err = 0;
  longint               cyc = 0;

  function automatic int taps_of(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 5 : 64);
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_u
    localparam int T = (g == 0) ? 4 : ((g == 1) ? 5 : 64);
    serial_fir_ctrl_if #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW)) bus ();
    assign bus.din_valid      = din_valid[g];
    assign bus.din_data       = din_data[g];
    assign bus.dout_ready     = dout_ready[g];
    assign bus.coef_data      = coef_tab[g][bus.coef_addr];
    assign bus.sram_read_data = mem[g][bus.sram_address];
    assign din_ready[g]       = bus.din_ready;
    assign coef_addr[g]       = bus.coef_addr;
    assign sram_address[g]    = bus.sram_address;
    assign sram_write_req[g]  = bus.sram_write_req;
    assign sram_write_data[g] = bus.sram_write_data;
    assign dout_valid[g]      = bus.dout_valid;
    assign dout_data[g]       = bus.dout_data;
    serial_fir_ctrl #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .TAPS(T)) dut (
      .clk(clk), .rst(rst[g]), .bus(bus), .o_dbg_state(dbg_state[g])
    );
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < NU; u++)
      if (sram_write_req[u]) mem[u][sram_address[u]] <= sram_write_data[u];
  end

  always @(negedge clk)
    for (int u = 0; u < NU; u++)
      if (rst[u] === 1'b0 && int'(sram_address[u]) >= taps_of(u)) addr_bad[u]++;

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] model_push(input int u, input logic signed [DW-1:0] x);
    longint s;
    s = 0;
    for (int i = 63; i > 0; i--) hist[u][i] = hist[u][i-1];
    hist[u][0] = x;
    for (int k = 0; k < taps_of(u); k++) s += longint'(coef_tab[u][k]) * longint'(hist[u][k]);
    return OW'(s);
  endfunction

  function automatic void model_clear(input int u);
    for (int i = 0; i < 64; i++) hist[u][i] = '0;
  endfunction

  function automatic logic [OW-1:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset(input int u);
    @(negedge clk); rst[u] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst[u] = 1'b0; #1;
    model_clear(u);
    exp_q.delete();
  endtask

  task automatic feed(input int u, input logic [DW-1:0] x, output bit ok,
                      output logic [AW-1:0] waddr, output longint acc_cyc);
    int n;
    n = 0;
    while (din_ready[u] !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
    ok      = (din_ready[u] === 1'b1);
    waddr   = sram_address[u];
    acc_cyc = -1;
    if (ok) begin
      din_valid[u] = 1'b1;
      din_data[u]  = x;
      exp_q.push_back(model_push(u, x));
      @(posedge clk); acc_cyc = cyc;
      @(negedge clk); din_valid[u] = 1'b0; #1;
    end
  endtask

  task automatic wait_dout(input int u, output int lat);
    lat = 1;
    while (dout_valid[u] !== 1'b1 && lat < 300) begin @(negedge clk); #1; lat++; end
    if (dout_valid[u] !== 1'b1) lat = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk); rst[0] = 1'b1; #1;
    n_vec++;
    if (din_ready[0] !== 1'b0 || dout_valid[0] !== 1'b0 || sram_write_req[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b valid=%b wreq=%b, want 0 0 0", din_ready[0], dout_valid[0], sram_write_req[0]);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst[0] = 1'b0; #1;
    model_clear(0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sram_write_req[0] !== 1'b1 || sram_address[0] !== AW'(i) || sram_write_data[0] !== '0 ||
          din_ready[0] !== 1'b0 || dout_valid[0] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_sweep[%0d]: wreq=%b addr=%0d wdata=%0d ready=%b valid=%b, want 1 %0d 0 0 0",
                 i, sram_write_req[0], sram_address[0], sram_write_data[0], din_ready[0], dout_valid[0], i);
      end
      @(negedge clk); #1;
    end
    n_vec++;
    if (din_ready[0] !== 1'b1 || sram_write_req[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_done: ready=%b wreq=%b, want 1 0", din_ready[0], sram_write_req[0]);
    end
  endtask

  task automatic test_impulse();
    logic [DW-1:0] xs[5];
    logic [OW-1:0] ys[5];
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    bit ok;
    int lat;
    xs = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    ys = '{22'd1, 22'd2, 22'd3, 22'd4, 22'd0};
    dout_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feed(0, xs[i], ok, wa, ac);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL impulse_accept[%0d]: not accepted, want accepted", i); end
      wait_dout(0, lat);
      n_vec++;
      if (lat != 5) begin n_err++; $display("FAIL impulse_latency[%0d]: got %0d want 5", i, lat); end
      e = pop_exp();
      n_vec++;
      if (dout_data[0] !== e || dout_data[0] !== ys[i]) begin
        n_err++;
        $display("FAIL impulse_data[%0d]: got %0d want %0d (model %0d)", i, dout_data[0], ys[i], e);
      end
      @(negedge clk); #1;
      n_vec++;
      if (dout_valid[0] !== 1'b0) begin n_err++; $display("FAIL impulse_valid_drop[%0d]: got %b want 0", i, dout_valid[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    bit ok;
    int lat;
    dout_ready[0] = 1'b0;
    feed(0, 8'd3, ok, wa, ac);
    wait_dout(0, lat);
    n_vec++;
    if (!ok || lat != 5) begin n_err++; $display("FAIL bp_first: ok=%b lat=%0d, want 1 5", ok, lat); end
    held = dout_data[0];
    e = pop_exp();
    n_vec++;
    if (held !== e) begin n_err++; $display("FAIL bp_data: got %0d want %0d", $signed(held), $signed(e)); end
    din_valid[0] = 1'b1;
    din_data[0]  = 8'hF9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (dout_valid[0] !== 1'b1 || dout_data[0] !== held || din_ready[0] !== 1'b0 || sram_write_req[0] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: valid=%b data=%0d ready=%b wreq=%b, want 1 %0d 0 0",
                 i, dout_valid[0], dout_data[0], din_ready[0], sram_write_req[0], held);
      end
    end
    dout_ready[0] = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (dout_valid[0] !== 1'b0 || din_ready[0] !== 1'b1 || sram_write_req[0] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ready=%b wreq=%b, want 0 1 1", dout_valid[0], din_ready[0], sram_write_req[0]);
    end
    exp_q.push_back(model_push(0, 8'hF9));
    @(posedge clk);
    @(negedge clk); din_valid[0] = 1'b0; #1;
    wait_dout(0, lat);
    e = pop_exp();
    n_vec++;
    if (lat != 5 || dout_data[0] !== e) begin
      n_err++;
      $display("FAIL bp_next: lat=%0d data=%0d, want 5 %0d", lat, $signed(dout_data[0]), $signed(e));
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_mac();
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    bit ok;
    int lat;
    dout_ready[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      feed(0, (i == 0) ? 8'd5 : 8'd7, ok, wa, ac);
      wait_dout(0, lat);
      e = pop_exp();
      n_vec++;
      if (!ok || dout_data[0] !== e) begin
        n_err++;
        $display("FAIL midmac_history[%0d]: ok=%b data=%0d want %0d", i, ok, dout_data[0], e);
      end
    end
    feed(0, 8'd9, ok, wa, ac);
    @(negedge clk);
    rst[0] = 1'b1; #1;
    n_vec++;
    if (dout_valid[0] !== 1'b0 || din_ready[0] !== 1'b0 || sram_write_req[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midmac_rst_outputs: valid=%b ready=%b wreq=%b, want 0 0 0", dout_valid[0], din_ready[0], sram_write_req[0]);
    end
    @(posedge clk);
    @(negedge clk); rst[0] = 1'b0; #1;
    exp_q.delete();
    model_clear(0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sram_write_req[0] !== 1'b1 || sram_address[0] !== AW'(i) || sram_write_data[0] !== '0 || dout_valid[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midmac_sweep[%0d]: wreq=%b addr=%0d wdata=%0d valid=%b, want 1 %0d 0 0",
                 i, sram_write_req[0], sram_address[0], sram_write_data[0], dout_valid[0], i);
      end
      @(negedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      feed(0, (i == 0) ? 8'd1 : 8'd0, ok, wa, ac);
      wait_dout(0, lat);
      e = pop_exp();
      n_vec++;
      if (lat != 5 || dout_data[0] !== e || dout_data[0] !== OW'(i + 1)) begin
        n_err++;
        $display("FAIL midmac_impulse[%0d]: lat=%0d data=%0d, want 5 %0d", i, lat, dout_data[0], i + 1);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    longint prev;
    bit ok;
    int lat;
    for (int k = 0; k < 4; k++) coef_tab[0][k] = CW'($urandom_range(0, 255));
    dout_ready[0] = 1'b1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      feed(0, DW'($urandom_range(0, 255)), ok, wa, ac);
      n_vec++;
      if (i > 0 && ac - prev != 6) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want 6", i, ac - prev); end
      prev = ac;
      wait_dout(0, lat);
      e = pop_exp();
      n_vec++;
      if (lat != 5 || dout_data[0] !== e) begin
        n_err++;
        $display("FAIL b2b_data[%0d]: lat=%0d data=%0d, want 5 %0d", i, lat, $signed(dout_data[0]), $signed(e));
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); dout_ready[0] = 1'b0; #1;
      feed(0, DW'($urandom_range(0, 255)), ok, wa, ac);
      wait_dout(0, lat);
      repeat ($urandom_range(0, 4)) begin @(negedge clk); #1; end
      e = pop_exp();
      n_vec++;
      if (!ok || dout_valid[0] !== 1'b1 || dout_data[0] !== e) begin
        n_err++;
        $display("FAIL stall_data[%0d]: ok=%b valid=%b data=%0d, want 1 1 %0d", i, ok, dout_valid[0], $signed(dout_data[0]), $signed(e));
      end
      dout_ready[0] = 1'b1;
      @(posedge clk);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    bit ok;
    int lat;
    do_reset(1);
    dout_ready[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      feed(1, 8'd1, ok, wa, ac);
      n_vec++;
      if (!ok || wa !== AW'(i % 5)) begin n_err++; $display("FAIL wrap_wr_ptr[%0d]: ok=%b addr=%0d want %0d", i, ok, wa, i % 5); end
      wait_dout(1, lat);
      e = pop_exp();
      n_vec++;
      if (lat != 6 || dout_data[1] !== e || dout_data[1] !== OW'((i < 5) ? i + 1 : 5)) begin
        n_err++;
        $display("FAIL wrap_data[%0d]: lat=%0d data=%0d, want 6 %0d", i, lat, dout_data[1], (i < 5) ? i + 1 : 5);
      end
    end
  endtask

  task automatic test_signed_extreme();
    logic [OW-1:0] e;
    logic [AW-1:0] wa;
    longint ac;
    bit ok;
    int lat;
    do_reset(2);
    dout_ready[2] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      feed(2, 8'h80, ok, wa, ac);
      wait_dout(2, lat);
      e = pop_exp();
      n_vec++;
      if (!ok || lat != 65 || dout_data[2] !== e) begin
        n_err++;
        $display("FAIL extreme_data[%0d]: ok=%b lat=%0d data=%0d, want 1 65 %0d", i, ok, lat, dout_data[2], e);
      end
      if (i == 0) begin
        n_vec++;
        if (dout_data[2] !== OW'(16384)) begin n_err++; $display("FAIL extreme_first: got %0d want 16384", dout_data[2]); end
      end
      if (i == 63) begin
        n_vec++;
        if (dout_data[2] !== OW'(1048576)) begin n_err++; $display("FAIL extreme_last: got %0d want 1048576", dout_data[2]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst[u]        = 1'b1;
      din_valid[u]  = 1'b0;
      din_data[u]   = '0;
      dout_ready[u] = 1'b0;
      model_clear(u);
      for (int k = 0; k < 64; k++)
        coef_tab[u][k] = (u == 0) ? ((k < 4) ? CW'(k + 1) : '0) : ((u == 1) ? 8'sd1 : -8'sd128);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst[1] = 1'b0; rst[2] = 1'b0;
    test_reset();
    test_impulse();
    test_backpressure();
    test_reset_mid_mac();
    test_back_to_back();
    test_wrap();
    test_signed_extreme();
    for (int u = 0; u < NU; u++) begin
      n_vec++;
      if (addr_bad[u] != 0) begin n_err++; $display("FAIL addr_range[%0d]: %0d out-of-range addresses, want 0", u, addr_bad[u]); end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
